// File: rtl/trackball_decoder.sv
// trackball_decoder: synchronized, glitch-filtered two-axis trackball step counters with CPU snapshot read
module trackball_decoder #(
  parameter int CNT_WIDTH = 4,
  parameter int FILT_CYCLES = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   h_clk,
  input  logic                   h_dir,
  input  logic                   v_clk,
  input  logic                   v_dir,
  input  logic                   flip,
  input  logic                   hold,
  input  logic                   clr,
  input  logic                   rd,
  output logic [2*CNT_WIDTH-1:0] dout,
  output logic                   dvalid
);
  localparam logic [3:0] RUN_LAST = 4'(FILT_CYCLES - 1);
  logic [3:0] s1, s2, f, acc;
  logic [3:0][3:0] run;
  logic [1:0] arm, step, up;
  logic [CNT_WIDTH-1:0] h_cnt, v_cnt;
  always_comb begin
    for (int i = 0; i < 4; i++) acc[i] = (s2[i] != f[i]) && (run[i] == RUN_LAST);
    for (int a = 0; a < 2; a++) begin
      step[a] = arm[a] && acc[2*a] && s2[2*a] && !hold;
      up[a] = f[2*a+1] ^ flip;
    end
  end
  always_ff @(posedge clk)
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
      f <= '0;
      run <= '0;
      arm <= '0;
      h_cnt <= '0;
      v_cnt <= '0;
      dout <= '0;
      dvalid <= 1'b0;
    end else begin
      s1 <= {v_dir, v_clk, h_dir, h_clk};
      s2 <= s1;
      for (int i = 0; i < 4; i++) begin
        run[i] <= (s2[i] == f[i] || acc[i]) ? 4'd0 : run[i] + 4'd1;
        if (acc[i]) f[i] <= s2[i];
      end
      arm <= arm | {acc[2], acc[0]};
      h_cnt <= clr ? '0 : step[0] ? h_cnt + {{(CNT_WIDTH-1){~up[0]}}, 1'b1} : h_cnt;
      v_cnt <= clr ? '0 : step[1] ? v_cnt + {{(CNT_WIDTH-1){~up[1]}}, 1'b1} : v_cnt;
      if (rd) dout <= {v_cnt, h_cnt};
      dvalid <= rd;
    end
endmodule

// File: tb/tb_trackball_decoder.sv
// tb_trackball_decoder: directed table-driven checks of trackball_decoder
module tb_trackball_decoder;
  logic clk = 1'b0;
  logic reset_n, h_clk, h_dir, v_clk, v_dir, flip, hold, clr, rd;
  logic [7:0] dout;
  logic dvalid;
  int errors = 0;
  int checks = 0;
  typedef struct {
    bit ax;
    bit dir;
    bit flp;
    bit hld;
    int n;
    logic [7:0] exp;
  } vec_t;
  vec_t tv[8];
  trackball_decoder #(.CNT_WIDTH(4), .FILT_CYCLES(3)) dut (
    .clk(clk), .reset_n(reset_n), .h_clk(h_clk), .h_dir(h_dir), .v_clk(v_clk),
    .v_dir(v_dir), .flip(flip), .hold(hold), .clr(clr), .rd(rd),
    .dout(dout), .dvalid(dvalid)
  );
  always #5 clk = ~clk;
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic rd_check(input string nm, input logic [7:0] exp);
    rd = 1'b1;
    cyc(1);
    rd = 1'b0;
    check(nm, dout, exp);
    check({nm, "_dv"}, {7'd0, dvalid}, 8'd1);
    cyc(1);
    check({nm, "_dv_low"}, {7'd0, dvalid}, 8'd0);
  endtask
  task automatic pulse(input bit ax, input int hi);
    if (ax) v_clk = 1'b1; else h_clk = 1'b1;
    cyc(hi);
    if (ax) v_clk = 1'b0; else h_clk = 1'b0;
    cyc(8);
  endtask
  task automatic set_dir(input bit ax, input bit d);
    if (ax) v_dir = d; else h_dir = d;
    cyc(8);
  endtask
  initial begin
    tv[0] = '{0, 1, 0, 0, 3, 8'h03};
    tv[1] = '{1, 0, 0, 0, 1, 8'hF3};
    tv[2] = '{1, 0, 1, 0, 2, 8'h13};
    tv[3] = '{0, 0, 1, 0, 2, 8'h15};
    tv[4] = '{0, 0, 0, 0, 1, 8'h14};
    tv[5] = '{1, 1, 0, 1, 4, 8'h14};
    tv[6] = '{0, 1, 0, 1, 4, 8'h14};
    tv[7] = '{0, 1, 0, 0, 1, 8'h15};
    reset_n = 1'b0;
    h_clk = 1'b1;
    v_clk = 1'b1;
    h_dir = 1'b1;
    v_dir = 1'b0;
    flip = 1'b0;
    hold = 1'b0;
    clr = 1'b0;
    rd = 1'b0;
    cyc(3);
    check("reset_dout", dout, 8'h00);
    check("reset_dvalid", {7'd0, dvalid}, 8'd0);
    reset_n = 1'b1;
    cyc(8);
    h_clk = 1'b0;
    v_clk = 1'b0;
    cyc(8);
    rd_check("arm_only", 8'h00);
    for (int k = 0; k < 8; k++) begin
      flip = tv[k].flp;
      hold = tv[k].hld;
      set_dir(tv[k].ax, tv[k].dir);
      repeat (tv[k].n) pulse(tv[k].ax, 8);
      hold = 1'b0;
      rd_check($sformatf("vec%0d", k), tv[k].exp);
    end
    pulse(0, 2);
    rd_check("glitch2", 8'h15);
    pulse(0, 4);
    rd_check("pulse4", 8'h16);
    set_dir(0, 0);
    pulse(0, 8);
    set_dir(0, 1);
    h_clk = 1'b1;
    cyc(4);
    rd = 1'b1;
    cyc(1);
    check("rd_step_snap", dout, 8'h15);
    check("rd_step_dv", {7'd0, dvalid}, 8'd1);
    cyc(1);
    rd = 1'b0;
    check("b2b_snap", dout, 8'h16);
    check("b2b_dv", {7'd0, dvalid}, 8'd1);
    cyc(1);
    check("b2b_dv_low", {7'd0, dvalid}, 8'd0);
    check("dout_hold", dout, 8'h16);
    cyc(3);
    h_clk = 1'b0;
    cyc(8);
    set_dir(1, 1);
    v_clk = 1'b1;
    cyc(4);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    cyc(4);
    v_clk = 1'b0;
    cyc(8);
    rd_check("clr_vs_step", 8'h00);
    pulse(1, 8);
    rd_check("after_clr", 8'h10);
    set_dir(1, 0);
    pulse(1, 8);
    pulse(1, 8);
    rd_check("dec_wrap", 8'hF0);
    set_dir(1, 1);
    for (int k = 1; k <= 16; k++) begin
      logic [3:0] v;
      v = 4'(15 + k);
      pulse(1, 8);
      rd_check($sformatf("wrap%0d", k), {v, 4'h0});
    end
    v_clk = 1'b1;
    cyc(3);
    reset_n = 1'b0;
    rd = 1'b1;
    clr = 1'b1;
    hold = 1'b1;
    cyc(1);
    check("midreset_dout", dout, 8'h00);
    check("midreset_dvalid", {7'd0, dvalid}, 8'd0);
    reset_n = 1'b1;
    rd = 1'b0;
    clr = 1'b0;
    hold = 1'b0;
    v_clk = 1'b0;
    cyc(8);
    rd_check("post_reset", 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
